// File: rtl/intersection_phase_ctrl_if.sv
// Lamp, request and status bundle between the intersection controller and its environment.
// The environment (master) drives tick and requests; the controller (slave) drives lamps and status.
interface intersection_phase_ctrl_if;
   logic       tick;
   logic       side_req;
   logic       ped_btn;
   logic [2:0] main_ryg;
   logic [2:0] side_ryg;
   logic       walk;
   logic       ped_ack;
   logic [2:0] phase;

   modport master (
      output tick, side_req, ped_btn,
      input  main_ryg, side_ryg, walk, ped_ack, phase
   );

   modport slave (
      input  tick, side_req, ped_btn,
      output main_ryg, side_ryg, walk, ped_ack, phase
   );
endinterface

// File: rtl/intersection_phase_ctrl.sv
// Phase sequencer for a main road, a side road and a pedestrian crossing; durations count external ticks.
// Lamps are a Moore decode of the state register; side and pedestrian requests are latched until served.
module intersection_phase_ctrl #(
   parameter int CNT_W    = 8,
   parameter int MAIN_MIN = 20,
   parameter int SIDE_GRN = 10,
   parameter int YEL      = 3,
   parameter int ALL_RED  = 2,
   parameter int WALK     = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   intersection_phase_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_ALL_RED_A = 3'd0,
      S_MAIN_GRN  = 3'd1,
      S_MAIN_YEL  = 3'd2,
      S_PED_WALK  = 3'd3,
      S_SIDE_GRN  = 3'd4,
      S_SIDE_YEL  = 3'd5,
      S_ALL_RED_B = 3'd6
   } state_e;

   localparam logic [CNT_W-1:0] MAIN_LAST = CNT_W'(MAIN_MIN - 1);
   localparam logic [CNT_W-1:0] SIDE_LAST = CNT_W'(SIDE_GRN - 1);
   localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YEL - 1);
   localparam logic [CNT_W-1:0] ARED_LAST = CNT_W'(ALL_RED - 1);
   localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   timer_q, timer_d;
   logic               side_pend_q, side_pend_d;
   logic               ped_pend_q, ped_pend_d;
   logic               ped_ack_q, ped_ack_d;

   logic               enter_side;
   logic               enter_ped;
   logic [2:0]         main_ryg;
   logic [2:0]         side_ryg;
   logic               walk;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_ALL_RED_A;
         timer_q     <= '0;
         side_pend_q <= 1'b0;
         ped_pend_q  <= 1'b0;
         ped_ack_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         side_pend_q <= side_pend_d;
         ped_pend_q  <= ped_pend_d;
         ped_ack_q   <= ped_ack_d;
      end
   end

   // Next-state decision
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_ALL_RED_A: begin
            if (bus.tick && timer_q == ARED_LAST) begin
               if (ped_pend_q)
                  state_d = S_PED_WALK;
               else if (side_pend_q)
                  state_d = S_SIDE_GRN;
               else
                  state_d = S_MAIN_GRN;
            end
         end
         S_MAIN_GRN: begin
            // Saturated timer means minimum green is met; a pending request then exits without a tick.
            if (timer_q == MAIN_LAST && (side_pend_q || ped_pend_q))
               state_d = S_MAIN_YEL;
         end
         S_MAIN_YEL: begin
            if (bus.tick && timer_q == YEL_LAST)
               state_d = S_ALL_RED_A;
         end
         S_PED_WALK: begin
            if (bus.tick && timer_q == WALK_LAST)
               state_d = side_pend_q ? S_SIDE_GRN : S_ALL_RED_B;
         end
         S_SIDE_GRN: begin
            if (bus.tick && timer_q == SIDE_LAST)
               state_d = S_SIDE_YEL;
         end
         S_SIDE_YEL: begin
            if (bus.tick && timer_q == YEL_LAST)
               state_d = S_ALL_RED_B;
         end
         S_ALL_RED_B: begin
            if (bus.tick && timer_q == ARED_LAST)
               state_d = S_MAIN_GRN;
         end
         default: state_d = S_ALL_RED_A;
      endcase
   end

   // Phase timer and request latches
   always_comb begin
      enter_side = (state_d == S_SIDE_GRN) && (state_q != S_SIDE_GRN);
      enter_ped  = (state_d == S_PED_WALK) && (state_q != S_PED_WALK);

      timer_d = timer_q;
      if (state_d != state_q)
         timer_d = '0;
      else if (bus.tick && !(state_q == S_MAIN_GRN && timer_q == MAIN_LAST))
         timer_d = timer_q + CNT_W'(1);

      // A request arriving on the entry clock is consumed by the phase being entered.
      if (enter_side)
         side_pend_d = 1'b0;
      else
         side_pend_d = side_pend_q || (bus.side_req && state_q != S_SIDE_GRN);

      if (enter_ped)
         ped_pend_d = 1'b0;
      else
         ped_pend_d = ped_pend_q || (bus.ped_btn && state_q != S_PED_WALK);

      ped_ack_d = enter_ped;
   end

   // Moore lamp decode
   always_comb begin
      main_ryg = 3'b100;
      side_ryg = 3'b100;
      walk     = 1'b0;
      case (state_q)
         S_MAIN_GRN: main_ryg = 3'b001;
         S_MAIN_YEL: main_ryg = 3'b010;
         S_SIDE_GRN: side_ryg = 3'b001;
         S_SIDE_YEL: side_ryg = 3'b010;
         S_PED_WALK: walk     = 1'b1;
         default: ;
      endcase
   end

   assign bus.main_ryg = main_ryg;
   assign bus.side_ryg = side_ryg;
   assign bus.walk     = walk;
   assign bus.ped_ack  = ped_ack_q;
   assign bus.phase    = state_q;

   // Safety invariants
   a_no_dual_green: assert property (@(posedge clk) disable iff (rst)
      !(main_ryg[0] && side_ryg[0]));
   a_lamps_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot(main_ryg) && $onehot(side_ryg));
   a_walk_all_red: assert property (@(posedge clk) disable iff (rst)
      walk |-> (main_ryg == 3'b100 && side_ryg == 3'b100));
   a_main_grn_to_yel: assert property (@(posedge clk) disable iff (rst)
      (state_q == S_MAIN_GRN && state_d != S_MAIN_GRN) |-> state_d == S_MAIN_YEL);
   a_main_yel_to_red: assert property (@(posedge clk) disable iff (rst)
      (state_q == S_MAIN_YEL && state_d != S_MAIN_YEL) |-> state_d == S_ALL_RED_A);
   a_side_grn_to_yel: assert property (@(posedge clk) disable iff (rst)
      (state_q == S_SIDE_GRN && state_d != S_SIDE_GRN) |-> state_d == S_SIDE_YEL);
   a_side_yel_to_red: assert property (@(posedge clk) disable iff (rst)
      (state_q == S_SIDE_YEL && state_d != S_SIDE_YEL) |-> state_d == S_ALL_RED_B);

endmodule

// File: tb/tb_intersection_phase_ctrl.sv
// Scoreboard bench: each test queues the expected per-clock phase sequence, then drives stimulus
// and pops one entry per clock, comparing phase, lamps, walk and ped_ack.
module tb_intersection_phase_ctrl;

   typedef struct packed {
      logic [2:0] ph;
      logic       ack;
   } exp_t;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;
   int   k;
   exp_t sb_q[$];

   intersection_phase_ctrl_if bus ();

   intersection_phase_ctrl #(
      .CNT_W    (8),
      .MAIN_MIN (4),
      .SIDE_GRN (3),
      .YEL      (2),
      .ALL_RED  (1),
      .WALK     (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] main_lamps(input logic [2:0] ph);
      case (ph)
         3'd1:    return 3'b001;
         3'd2:    return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] side_lamps(input logic [2:0] ph);
      case (ph)
         3'd4:    return 3'b001;
         3'd5:    return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   // Queue n clocks of phase ph; ped_ack is expected only on the first clock of a walk run.
   task automatic push(input logic [2:0] ph, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.ph  = ph;
         e.ack = (ph == 3'd3) && (i == 0);
         sb_q.push_back(e);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b1;
      bus.tick     = 1'b0;
      bus.side_req = 1'b0;
      bus.ped_btn  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      k   = 0;
   endtask

   // Each clock: compare against the scoreboard at the negedge, then drive inputs for the next posedge.
   task automatic run(input int n, input logic s, input logic p, input int tdiv);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("phase",    bus.phase,    e.ph);
            chk("main_ryg", bus.main_ryg, main_lamps(e.ph));
            chk("side_ryg", bus.side_ryg, side_lamps(e.ph));
            chk("walk",     bus.walk,     e.ph == 3'd3);
            chk("ped_ack",  bus.ped_ack,  e.ack);
         end
         bus.side_req = s;
         bus.ped_btn  = p;
         bus.tick     = ((k % tdiv) == (tdiv - 1));
         @(posedge clk);
         @(negedge clk);
         k++;
      end
   endtask

   initial begin
      n_chk        = 0;
      n_err        = 0;
      k            = 0;
      rst          = 1'b1;
      bus.tick     = 1'b0;
      bus.side_req = 1'b0;
      bus.ped_btn  = 1'b0;

      // 1: no requests, main green held
      do_reset();
      chk("rst_side_pend", dut.side_pend_q, 1'b0);
      chk("rst_ped_pend",  dut.ped_pend_q,  1'b0);
      push(3'd0, 1); push(3'd1, 100);
      run(101, 1'b0, 1'b0, 1);
      chk("t1_drained", sb_q.size(), 0);

      // 2: side request served after minimum main green
      do_reset();
      push(3'd0, 1); push(3'd1, 4); push(3'd2, 2); push(3'd0, 1);
      push(3'd4, 3); push(3'd5, 2); push(3'd6, 1); push(3'd1, 5);
      run(1, 1'b1, 1'b0, 1);
      run(6, 1'b0, 1'b0, 1);
      chk("t2_side_pend_set", dut.side_pend_q, 1'b1);
      run(1, 1'b0, 1'b0, 1);
      chk("t2_side_pend_clr", dut.side_pend_q, 1'b0);
      run(11, 1'b0, 1'b0, 1);
      chk("t2_drained", sb_q.size(), 0);

      // 3: side and pedestrian together; walk first, then side green
      do_reset();
      push(3'd0, 1); push(3'd1, 4); push(3'd2, 2); push(3'd0, 1);
      push(3'd3, 2); push(3'd4, 3); push(3'd5, 2); push(3'd6, 1); push(3'd1, 4);
      run(1, 1'b1, 1'b1, 1);
      run(19, 1'b0, 1'b0, 1);
      chk("t3_drained", sb_q.size(), 0);

      // 4: tick on every 4th clock (k%4==3); side request during the first main-green clock.
      // Saturated main green exits on the next clock with no tick, so it spans 3*4+1 clocks;
      // main yellow is entered one clock after a tick, so its two ticks span 7 clocks.
      do_reset();
      push(3'd0, 4); push(3'd1, 13); push(3'd2, 7); push(3'd0, 4);
      push(3'd4, 12); push(3'd5, 8); push(3'd6, 4); push(3'd1, 8);
      run(4, 1'b0, 1'b0, 4);
      run(1, 1'b1, 1'b0, 4);
      run(55, 1'b0, 1'b0, 4);
      chk("t4_drained", sb_q.size(), 0);

      // 5: async reset in the middle of side green
      do_reset();
      push(3'd0, 1); push(3'd1, 4); push(3'd2, 2); push(3'd0, 1); push(3'd4, 2);
      run(1, 1'b1, 1'b0, 1);
      run(7, 1'b0, 1'b0, 1);
      run(1, 1'b0, 1'b1, 1);
      run(1, 1'b0, 1'b0, 1);
      chk("t5_ped_pend_pre", dut.ped_pend_q, 1'b1);
      chk("t5_phase_pre",    bus.phase,      3'd4);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_phase",     bus.phase,       3'd0);
      chk("t5_main_ryg",  bus.main_ryg,    3'b100);
      chk("t5_side_ryg",  bus.side_ryg,    3'b100);
      chk("t5_walk",      bus.walk,        1'b0);
      chk("t5_ped_ack",   bus.ped_ack,     1'b0);
      chk("t5_side_pend", dut.side_pend_q, 1'b0);
      chk("t5_ped_pend",  dut.ped_pend_q,  1'b0);
      chk("t5_drained", sb_q.size(), 0);

      // 6: ped_btn held high; blocked during walk, re-latched in the following all-red
      do_reset();
      push(3'd0, 1); push(3'd1, 4); push(3'd2, 2); push(3'd0, 1); push(3'd3, 2); push(3'd6, 1);
      push(3'd1, 4); push(3'd2, 2); push(3'd0, 1); push(3'd3, 2); push(3'd6, 1);
      push(3'd1, 4); push(3'd2, 2); push(3'd0, 1); push(3'd3, 2); push(3'd6, 1); push(3'd1, 6);
      run(10, 1'b0, 1'b1, 1);
      chk("t6_ped_pend_blocked", dut.ped_pend_q, 1'b0);
      run(1, 1'b0, 1'b1, 1);
      chk("t6_ped_pend_relatch", dut.ped_pend_q, 1'b1);
      run(10, 1'b0, 1'b1, 1);
      run(16, 1'b0, 1'b0, 1);
      chk("t6_ped_pend_final", dut.ped_pend_q, 1'b0);
      chk("t6_drained", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
